// File: rtl/risc_pkg.sv
// Shared datapath constants and types for the basic RISC core.
// Register-file default geometry plus address and data word typedefs.
package risc_pkg;

   localparam int RF_WIDTH = 8;
   localparam int RF_DEPTH = 8;
   localparam int RF_AW    = $clog2(RF_DEPTH);

   typedef logic [RF_AW-1:0]    reg_addr_t;
   typedef logic [RF_WIDTH-1:0] data_t;

endpackage

// File: rtl/rf_cell.sv
// Enabled WIDTH-bit register with async active-low reset to RESET_VAL.
// Latency 1 cycle; no backpressure, holds its value while en is low.
module rf_cell #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one write port, two enabled registered read ports with write forwarding.
// Read latency 1 cycle; no backpressure, disabled read ports hold their last value.
module reg_file
   import risc_pkg::*;
#(
   parameter int               WIDTH     = RF_WIDTH,
   parameter int               DEPTH     = RF_DEPTH,
   parameter bit               ZERO_R0   = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              AW        = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WE,
   input  logic [AW-1:0]    WADDR,
   input  logic [WIDTH-1:0] WDATA,
   input  logic             REN_A,
   input  logic [AW-1:0]    RADDR_A,
   output logic [WIDTH-1:0] RDATA_A,
   input  logic             REN_B,
   input  logic [AW-1:0]    RADDR_B,
   output logic [WIDTH-1:0] RDATA_B
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_a_nxt;
   logic [WIDTH-1:0] rd_b_nxt;

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      if (ZERO_R0 && i == 0) begin : g_zero
         assign mem_q[i] = '0;
      end else begin : g_store
         logic wr_en;
         assign wr_en = WE && (WADDR == AW'(i));

         rf_cell #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
         ) u_cell (
            .CLK  (CLK),
            .RST_N(RST_N),
            .en   (wr_en),
            .d    (WDATA),
            .q    (mem_q[i])
         );
      end
   end

   // Forwarded write data wins over the stored word; the zero register overrides both.
   always_comb begin
      rd_a_nxt = mem_q[RADDR_A];
      if (WE && (WADDR == RADDR_A)) begin
         rd_a_nxt = WDATA;
      end
      if (ZERO_R0 && (RADDR_A == '0)) begin
         rd_a_nxt = '0;
      end
   end

   always_comb begin
      rd_b_nxt = mem_q[RADDR_B];
      if (WE && (WADDR == RADDR_B)) begin
         rd_b_nxt = WDATA;
      end
      if (ZERO_R0 && (RADDR_B == '0)) begin
         rd_b_nxt = '0;
      end
   end

   rf_cell #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
   ) u_rd_a (
      .CLK  (CLK),
      .RST_N(RST_N),
      .en   (REN_A),
      .d    (rd_a_nxt),
      .q    (RDATA_A)
   );

   rf_cell #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
   ) u_rd_b (
      .CLK  (CLK),
      .RST_N(RST_N),
      .en   (REN_B),
      .d    (rd_b_nxt),
      .q    (RDATA_B)
   );

endmodule
